// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of a 5-stage DLX pipeline.
// Owns the PC, reads a combinational instruction memory and drives the
// IF/ID register (instruc, current_PC = fetch PC + 1). Handles decode-stage
// jump/branch redirects, hazard stalls and a HALT opcode that freezes fetch
// until a resume pulse.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   imem_addr  (out)      instruction memory address (the PC)
//   imem_data  (in)       instruction word read combinationally at imem_addr
//   stall                 hold PC and IF/ID (redirects ignored)
//   branch_sel/_address   taken branch and its target
//   jump_sel/_address     jump and its target (wins over branch)
//   resume                single-cycle pulse that leaves HALT
//   instruc    (out)      IF/ID instruction register
//   current_PC (out)      IF/ID fetch PC + 1
//   halted     (out)      high while in HALT
//   fetch_count (out)     only with IF_FETCH_COUNT_EN: saturating count of
//                         sequential fetches (halt word included)
//
// Optional feature macro: IF_FETCH_COUNT_EN.
module instruction_fetch #(
    parameter int unsigned         PC_WIDTH    = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                stall,
    input  logic                branch_sel,
    input  logic [PC_WIDTH-1:0] branch_address,
    input  logic                jump_sel,
    input  logic [PC_WIDTH-1:0] jump_address,
    input  logic                resume,
    output logic [31:0]         instruc,
    output logic [PC_WIDTH-1:0] current_PC,
`ifdef IF_FETCH_COUNT_EN
    output logic                halted,
    output logic [31:0]         fetch_count
`else
    output logic                halted
`endif
);

    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [INSTR_WIDTH-1:0] instruc_next;
    logic [PC_WIDTH-1:0]    current_pc_next;
    logic                   halted_next;
    logic                   fetch_en;

    // PC drives the memory directly; wraps naturally at 2^PC_WIDTH.
    assign imem_addr = pc;
    assign pc_plus1  = pc + PC_WIDTH'(1);

    // State, PC and IF/ID registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            instruc    <= '0;
            current_PC <= '0;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instruc    <= instruc_next;
            current_PC <= current_pc_next;
            halted     <= halted_next;
        end
    end

    // Next-state and IF/ID selection; stall outranks jump, jump outranks branch.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instruc_next    = instruc;
        current_pc_next = current_PC;
        fetch_en        = 1'b0;

        case (state)
            S_RUN: begin
                if (stall) begin
                    // decode-stage instruction not valid yet: hold everything
                end else if (jump_sel) begin
                    pc_next         = jump_address;
                    instruc_next    = '0;
                    current_pc_next = '0;
                end else if (branch_sel) begin
                    pc_next         = branch_address;
                    instruc_next    = '0;
                    current_pc_next = '0;
                end else begin
                    fetch_en        = 1'b1;
                    pc_next         = pc_plus1;
                    instruc_next    = imem_data;
                    current_pc_next = pc_plus1;
                    // Only a halt word that actually reaches IF/ID freezes fetch.
                    if (imem_data[31:26] == HALT_OPCODE) begin
                        state_next = S_HALT;
                    end
                end
            end
            S_HALT: begin
                instruc_next    = '0;
                current_pc_next = '0;
                if (resume) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase

        halted_next = (state_next == S_HALT);
    end

`ifdef IF_FETCH_COUNT_EN
    // Saturating count of sequential fetches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
        end else if (fetch_en && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'(1);
        end
    end
`endif

endmodule
